ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the outbound counterpart of the existing ps2_keyboard receiver.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the host-request-to-send sequence.
- Drives the shared ps2_clk and ps2_data open-drain lines through active-high pull-low enables.
- Asserts rx_inhibit while transmitting so top-level muxing blocks the receiver from capturing host-generated frames.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles allowed between device clock falling edges, or waiting for line release, before abort.
- SYNC_STAGES, 3: flop stages on ps2_clk_i and ps2_data_i; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high in IDLE; byte accepted when tx_valid && tx_ready
- ps2_clk_i  in  1  raw PS/2 clock line level
- ps2_data_i  in  1  raw PS/2 data line level
- ps2_clk_oe  out  1  1 = pull ps2_clk low
- ps2_data_oe  out  1  1 = pull ps2_data low
- busy  out  1  transfer in progress (not IDLE)
- rx_inhibit  out  1  equals busy
- done  out  1  1-cycle pulse: byte sent and ACKed
- ack_err  out  1  1-cycle pulse: device did not ACK (data high at ACK edge)
- timeout  out  1  1-cycle pulse: TIMEOUT_CYCLES expired

Behaviour:
- Reset: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1 (IDLE after reset), busy=0, rx_inhibit=0, done=0, ack_err=0, timeout=0; counters cleared; state IDLE.
- Reset mid-transfer releases both lines on the next clk edge; no status pulse.
- Inputs pass through SYNC_STAGES synchronizer. A falling edge (fe) is synchronized level 1 then 0, registered as a 1-cycle pulse.
- Shift register holds {stop=1, parity, tx_data[7:0]}. Parity is odd: ~^tx_data.
- IDLE: tx_ready=1. On accept, latch data and parity, then go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: data_oe=1 (start bit 0) and clk_oe=0, set on the same edge. Go to SEND; bit index=0, timeout counter cleared.
- SEND: on each fe, data_oe = ~shift[idx] and idx increments.
  - fe 1..8 present data bits 0..7, LSB first.
  - fe 9 presents parity.
  - fe 10 presents stop; data_oe=0.
  - Then go to ACK.
- ACK: on next fe, sample synchronized data. 0 sets ok; 1 sets ack_err pending. Go to RELEASE.
- RELEASE: wait until synced clk=1 and data=1. Then pulse done (or ack_err) and return to IDLE. tx_ready is high the cycle after the pulse.
- Timeout:
  - The counter runs in REQ, SEND, ACK and RELEASE, and clears on every fe.
  - Reaching TIMEOUT_CYCLES-1 releases both lines, pulses timeout, and returns to IDLE.
  - Timeout has priority over a coincident fe.
- tx_valid while busy is ignored; tx_data is not sampled.
- Only one status pulse per accepted byte.
- Counter widths: $clog2 of the parameter plus 1; no wrap.

Optional Feature:
- PS2_TX_RETRY_EN defined: on NACK or timeout, retry the latched byte once from INHIBIT with no pulse on the first failure. A second failure pulses ack_err or timeout. busy stays high across the retry.
- Undefined: the first failure pulses immediately.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, REQ, SEND, ACK, RELEASE
  - command constants: PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ECHO=8'hEE
  - response constants: PS2_RSP_ACK=8'hFA, PS2_RSP_RESEND=8'hFE
  - frame bit count: 11
- One sub-module, ps2_sync_edge: parameterized synchronizer with falling-edge pulse output. Reused for ps2_clk and ps2_data.

Test Plan:
- Send 0xED, device model clocks at 12 kHz and ACKs -> clk_oe low for exactly 5000 cycles; device samples 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; tx_ready returns 1.
- Send 0x00 -> all data bits 0, parity 1; done pulses.
- Device leaves data high at ACK edge -> ack_err pulse; both oe=0; no done pulse.
- Device never clocks after REQ, TIMEOUT_CYCLES=2000 -> timeout pulse 2000 cycles after REQ; lines released; IDLE.
- rst asserted after fe 4 -> next cycle clk_oe=data_oe=0, busy=0, no pulses. New tx_valid accepted.
- tx_valid held with different tx_data during a transfer -> ignored. With PS2_TX_RETRY_EN, one NACK then ACK -> single done pulse, two INHIBIT phases.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared PS/2 definitions used by the host transmitter and the existing
//   keyboard receiver side of the codebase.
//
//   Contents:
//     ps2_tx_state_e    host-to-device transmitter state encoding
//     PS2_CMD_*         common host command bytes
//     PS2_RSP_*         common device response bytes
//     PS2_FRAME_BITS    bits per frame: start, 8 data, parity, stop
//     ps2_odd_parity()  parity bit that makes the 9-bit {parity,data} odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQ     = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;

    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
//   Multi-flop synchronizer for one asynchronous PS/2 line, plus a registered
//   falling-edge pulse derived from the synchronized level.
//
//   Parameters:
//     SYNC_STAGES  flop stages in the synchronizer chain (minimum 2)
//     IDLE_LEVEL   value the chain is reset to (PS/2 lines idle high)
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous, active-high reset
//     in_i     in   raw line level
//     level_o  out  synchronized line level
//     fe_o     out  1-cycle pulse: synchronized level went 1 -> 0
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
    parameter int   SYNC_STAGES = 3,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic level_o,
    output logic fe_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fe_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to the idle level so leaving reset never fakes an edge.
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
            fe_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            fe_q   <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the device
//   using the host-request-to-send sequence: hold ps2_clk low, pull ps2_data
//   low (start bit), release ps2_clk, then shift data/parity/stop out on the
//   device's falling clock edges and read the device ACK bit.
//
//   Parameters:
//     INHIBIT_CYCLES  clk cycles ps2_clk is held low before the request
//     TIMEOUT_CYCLES  max clk cycles between device clock falling edges, or
//                     waiting for line release, before the transfer aborts
//     SYNC_STAGES     synchronizer depth on ps2_clk_i / ps2_data_i (>= 2)
//
//   Compile-time option:
//     PS2_TX_RETRY_EN  when defined, a NACK or timeout re-sends the latched
//                      byte once from INHIBIT before reporting the failure.
//
//   Ports:
//     clk, rst      system clock, synchronous active-high reset
//     tx_valid      request to send tx_data
//     tx_data       command byte
//     tx_ready      high in IDLE; byte accepted on tx_valid && tx_ready
//     ps2_clk_i     raw ps2_clk line level
//     ps2_data_i    raw ps2_data line level
//     ps2_clk_oe    1 = pull ps2_clk low
//     ps2_data_oe   1 = pull ps2_data low
//     busy          transfer in progress
//     rx_inhibit    equals busy; blocks the receiver during host frames
//     done          1-cycle pulse: byte sent and ACKed
//     ack_err       1-cycle pulse: device did not ACK
//     timeout       1-cycle pulse: device went silent for TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W   = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int SHIFT_W = PS2_FRAME_BITS - 1;   // start bit is driven in REQ

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       STOP_IDX = 4'(SHIFT_W - 1);

`ifdef PS2_TX_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Line synchronizers
    // -----------------------------------------------------------------------
    logic clk_level;
    logic clk_fe;
    logic data_level;
    logic data_fe_unused;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b1)
    ) u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .in_i    (ps2_clk_i),
        .level_o (clk_level),
        .fe_o    (clk_fe)
    );

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b1)
    ) u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .in_i    (ps2_data_i),
        .level_o (data_level),
        .fe_o    (data_fe_unused)
    );

    // -----------------------------------------------------------------------
    // Transmit FSM with registered line enables and status pulses
    // -----------------------------------------------------------------------
    ps2_tx_state_e      state_q;
    logic               clk_oe_q;
    logic               data_oe_q;
    logic               done_q;
    logic               ack_err_q;
    logic               timeout_q;
    logic [INH_W-1:0]   inh_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [3:0]         idx_q;
    logic [SHIFT_W-1:0] shift_q;     // {stop, parity, data[7:0]}
    logic               nack_q;
    logic               retried_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            idx_q     <= '0;
            // NOTE: the shift register is reset only for clean, deterministic
            // state; it is always reloaded on accept before being read.
            shift_q   <= '0;
            nack_q    <= 1'b0;
            retried_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (tx_valid) begin
                        shift_q   <= {1'b1, ps2_odd_parity(tx_data), tx_data};
                        retried_q <= 1'b0;
                        nack_q    <= 1'b0;
                        inh_cnt_q <= '0;
                        clk_oe_q  <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        // Start bit and clock release on the same edge.
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        to_cnt_q  <= '0;
                        idx_q     <= '0;
                        state_q   <= REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end

                REQ, SEND, ACK, RELEASE: begin
                    if (to_cnt_q == TO_LAST) begin
                        // Device went silent; this wins over a coincident edge.
                        if (RETRY_EN && !retried_q) begin
                            retried_q <= 1'b1;
                            inh_cnt_q <= '0;
                            clk_oe_q  <= 1'b1;
                            data_oe_q <= 1'b0;
                            state_q   <= INHIBIT;
                        end else begin
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b0;
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else begin
                        to_cnt_q <= clk_fe ? '0 : to_cnt_q + 1'b1;

                        case (state_q)
                            REQ: state_q <= SEND;

                            SEND: begin
                                if (clk_fe) begin
                                    data_oe_q <= ~shift_q[idx_q];
                                    idx_q     <= idx_q + 4'd1;
                                    if (idx_q == STOP_IDX) begin
                                        state_q <= ACK;
                                    end
                                end
                            end

                            ACK: begin
                                if (clk_fe) begin
                                    // Device pulls data low to acknowledge.
                                    nack_q  <= data_level;
                                    state_q <= RELEASE;
                                end
                            end

                            default: begin   // RELEASE
                                if (clk_level && data_level) begin
                                    if (!nack_q) begin
                                        done_q  <= 1'b1;
                                        state_q <= IDLE;
                                    end else if (RETRY_EN && !retried_q) begin
                                        retried_q <= 1'b1;
                                        nack_q    <= 1'b0;
                                        inh_cnt_q <= '0;
                                        clk_oe_q  <= 1'b1;
                                        data_oe_q <= 1'b0;
                                        state_q   <= INHIBIT;
                                    end else begin
                                        ack_err_q <= 1'b1;
                                        state_q   <= IDLE;
                                    end
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    // Unused encodings: release the bus and recover.
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rx_inhibit  = busy;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Self-checking bench for ps2_host_tx. A behavioural PS/2 device clocks the
//   frame (time-scaled: half period H clk cycles), samples each host bit while
//   its clock is high and answers with ACK or NACK.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 5000;
    localparam int TO  = 2000;
    localparam int H   = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, rx_inhibit, done, ack_err, timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .rx_inhibit  (rx_inhibit),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Free-running count of cycles each status pulse is high.
    int done_seen = 0;
    int err_seen  = 0;
    int to_seen   = 0;
    always @(negedge clk) begin
        if (done)    done_seen <= done_seen + 1;
        if (ack_err) err_seen  <= err_seen + 1;
        if (timeout) to_seen   <= to_seen + 1;
    end

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        bit         ack1;      // device response on first attempt
        bit         ack2;      // device response on retry
        bit         hold;      // keep tx_valid high with other data while busy
        logic [9:0] bits;      // {stop, parity, data} as seen by the device
        int         done_nr;   // expected pulses, retry disabled
        int         err_nr;
        int         done_rt;   // expected pulses, retry enabled
        int         err_rt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for ps2_clk_oe to assert and returns how many cycles it stayed high.
    task automatic wait_inhibit(output int n);
        int guard = 0;
        while (!ps2_clk_oe && guard < 4 * TO) begin
            @(negedge clk);
            guard++;
        end
        n = 0;
        while (ps2_clk_oe && n < INH + 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One device-clocked frame: 10 clocks sampling data/parity/stop, then ACK clock.
    task automatic dev_frame(input bit ack, output logic [9:0] bits, output logic start_bit);
        start_bit = ps2_data_line;
        repeat (H) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H / 2) @(negedge clk);
            bits[k] = ps2_data_line;
            repeat (H / 2) @(negedge clk);
        end
        tx_valid     = 1'b0;
        dev_data_low = ack;
        repeat (H / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (H / 2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int         d0, e0, t0, n, frames, guard;
        logic [9:0] bits;
        logic       sb;
        bit         ack_now;
        int         exp_done, exp_err;
        d0 = done_seen; e0 = err_seen; t0 = to_seen;
        frames   = 1;
        exp_done = v.done_nr;
        exp_err  = v.err_nr;
`ifdef PS2_TX_RETRY_EN
        if (!v.ack1) frames = 2;
        exp_done = v.done_rt;
        exp_err  = v.err_rt;
`endif
        check("tx_ready before send", tx_ready, 1);
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clk);
        if (v.hold) tx_data = ~v.data;
        else        tx_valid = 1'b0;
        for (int f = 0; f < frames; f++) begin
            if (f > 0) check("busy across retry", busy, 1);
            wait_inhibit(n);
            check("inhibit length", n, INH);
            check("req data_oe", ps2_data_oe, 1);
            check("req clk_oe", ps2_clk_oe, 0);
            check("busy in transfer", busy, 1);
            check("rx_inhibit in transfer", rx_inhibit, 1);
            check("tx_ready in transfer", tx_ready, 0);
            ack_now = (f == 0) ? v.ack1 : v.ack2;
            dev_frame(ack_now, bits, sb);
            check("start bit", sb, 0);
            check("frame bits", bits, v.bits);
        end
        guard = 0;
        while (!tx_ready && guard < 4 * H) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("tx_ready after", tx_ready, 1);
        check("clk_oe after", ps2_clk_oe, 0);
        check("data_oe after", ps2_data_oe, 0);
        check("done pulses", done_seen - d0, exp_done);
        check("ack_err pulses", err_seen - e0, exp_err);
        check("timeout pulses", to_seen - t0, 0);
    endtask

    initial begin
        int n, d0, e0, t0;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 10'h3ED, 1, 0, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 10'h300, 1, 0, 1, 0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b1, 10'h201, 1, 0, 1, 0};
        vecs[3] = '{8'hEE, 1'b0, 1'b0, 1'b0, 10'h3EE, 0, 1, 0, 1};
        vecs[4] = '{8'hFA, 1'b0, 1'b1, 1'b0, 10'h3FA, 0, 1, 1, 0};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 10'h207, 1, 0, 1, 0};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst clk_oe", ps2_clk_oe, 0);
        check("rst data_oe", ps2_data_oe, 0);
        check("rst tx_ready", tx_ready, 1);
        check("rst busy", busy, 0);
        check("rst rx_inhibit", rx_inhibit, 0);
        check("rst pulses", {done, ack_err, timeout}, 3'b000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Device never clocks after the request.
        t0 = to_seen; d0 = done_seen; e0 = err_seen;
        tx_data  = PS2_CMD_RESET;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_inhibit(n);
        check("timeout inhibit length", n, INH);
        n = 0;
        while (!timeout && !ps2_clk_oe && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency", n, TO);
`ifdef PS2_TX_RETRY_EN
        check("no pulse on first timeout", timeout, 0);
        check("busy across timeout retry", busy, 1);
        wait_inhibit(n);
        check("retry inhibit length", n, INH);
        n = 0;
        while (!timeout && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        check("retry timeout latency", n, TO);
`endif
        check("timeout pulse", timeout, 1);
        check("timeout clk_oe", ps2_clk_oe, 0);
        check("timeout data_oe", ps2_data_oe, 0);
        check("timeout tx_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        check("timeout pulse count", to_seen - t0, 1);
        check("timeout no other pulses", (done_seen - d0) + (err_seen - e0), 0);

        // Reset after the fourth device falling edge.
        t0 = to_seen; d0 = done_seen; e0 = err_seen;
        tx_data  = PS2_CMD_SET_LEDS;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_inhibit(n);
        repeat (H) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k < 3) begin
                dev_clk_low = 1'b0;
                repeat (H) @(negedge clk);
            end
        end
        check("mid-frame busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst clk_oe", ps2_clk_oe, 0);
        check("mid rst data_oe", ps2_data_oe, 0);
        check("mid rst busy", busy, 0);
        check("mid rst tx_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        check("mid rst no pulses", (to_seen - t0) + (done_seen - d0) + (err_seen - e0), 0);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
